// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl_if
//  Brief    : Pipeline hazard/sequencing bundle between the datapath side
//             (master: presents hazard sources, consumes enables/flushes)
//             and the stall controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if;
    // Hazard sources from the datapath
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [1:0]  exmem_mem;
    logic        branch_taken;
    logic        dmem_ack;

    // Sequencing controls back to the datapath
    logic        dmem_req;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        mem_err;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, idex_memread, idex_rt, exmem_mem, branch_taken, dmem_ack,
        input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, idex_memread, idex_rt, exmem_mem, branch_taken, dmem_ack,
        output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, mem_err, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl
//  Brief    : Five-stage pipeline sequencing controller. Produces register
//             enables and flush strobes for load-use hazards, taken branches
//             and multi-cycle data-memory accesses; detects memory timeouts
//             and counts stalled cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 15          // max MWAIT cycles without ack (1..255)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Last wait count value before declaring a timeout
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic w_mem_acc;
    logic w_load_use;
    logic w_mem_stall;
    logic w_err_hold;
    logic w_dmem_req;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush;

    assign w_mem_acc  = bus.exmem_mem[1] | bus.exmem_mem[0];
    assign w_load_use = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                        ((bus.idex_rt == bus.id_rs) || (bus.idex_rt == bus.id_rt));

    // Enables, flushes and request decoded from state plus current hazards, highest priority first
    always_comb begin
        w_mem_stall   = 1'b0;
        w_err_hold    = 1'b0;
        w_dmem_req    = 1'b0;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    w_dmem_req  = w_mem_acc;
                    w_mem_stall = w_mem_acc & ~bus.dmem_ack;
                end
                ST_MWAIT: begin
                    // The held EX/MEM access stays requested until acked
                    w_dmem_req  = 1'b1;
                    w_mem_stall = ~bus.dmem_ack;
                end
                ST_ERR: begin
                    w_err_hold  = 1'b1;
                end
                default: begin
                    w_err_hold  = 1'b1;
                end
            endcase

            if (w_err_hold || w_mem_stall) begin
                // Freeze the whole pipeline; branch/load-use wait for release
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_idex_en  = 1'b0;
                w_exmem_en = 1'b0;
                w_memwb_en = 1'b0;
            end else if (bus.branch_taken) begin
                // Squash the three younger instructions; load-use among them is moot
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
                w_exmem_flush = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF/ID one cycle, push a bubble into ID/EX
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
            end
        end
    end

    // Next-state, wait counter and saturating stall counter
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (w_mem_acc && !bus.dmem_ack) begin
                    state_d    = ST_MWAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MWAIT: begin
                if (bus.dmem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == C_WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        if (!w_pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.dmem_req    = w_dmem_req;
    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.mem_err     = (state_q == ST_ERR);
    assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_stall_ctrl
//  Brief    : Scoreboard bench for hazard_stall_ctrl with a behavioural model
//             of the sequencing rules, directed corner cases and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected output vector per cycle:
    // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, exmem_flush, mem_err, stall_cnt[15:0]}
    logic [25:0] exp_q[$];

    // Behavioural model state
    int m_pend   = 0;   // consecutive unacked cycles of the current access
    bit m_err    = 0;
    int m_stalls = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of inputs, predict outputs, advance the model
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] xrt, input logic [1:0] xm,
                        input logic br, input logic ack);
        bit mem_acc, lu, req, stall_all;
        bit pc, ifid, rest, fif, fid, fex;
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.idex_memread = mr;
        bus.idex_rt      = xrt;
        bus.exmem_mem    = xm;
        bus.branch_taken = br;
        bus.dmem_ack     = ack;

        mem_acc = (xm != 2'b00);
        lu      = mr && (xrt != 0) && (xrt == rs || xrt == rt);
        req = 0; pc = 1; ifid = 1; rest = 1; fif = 0; fid = 0; fex = 0; stall_all = 0;
        if (!r) begin
            if (m_err) begin
                stall_all = 1;
            end else begin
                req = (m_pend > 0) || mem_acc;
                if (req && !ack)  stall_all = 1;
                else if (br)      begin fif = 1; fid = 1; fex = 1; end
                else if (lu)      begin pc = 0; ifid = 0; fid = 1; end
            end
            if (stall_all) begin pc = 0; ifid = 0; rest = 0; end
        end
        exp_q.push_back({req, pc, ifid, rest, rest, rest, fif, fid, fex, m_err, 16'(m_stalls)});

        if (r) begin
            m_pend = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (!pc && m_stalls < 65535) m_stalls++;
            if (!m_err && req) begin
                if (ack) m_pend = 0;
                else begin
                    m_pend++;
                    // Request has been high TIMEOUT+1 cycles with no ack
                    if (m_pend == TO + 1) m_err = 1;
                end
            end
        end
    endtask

    task automatic idle(input logic r);
        step(r, 5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    initial begin
        logic [25:0] act, expv;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                act  = {bus.dmem_req, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                        bus.memwb_en, bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                        bus.mem_err, bus.stall_cnt};
                chk("cycle_outputs", 32'(act), 32'(expv));
            end
        end
    end

    initial begin
        bus.id_rs = 0; bus.id_rt = 0; bus.idex_memread = 0; bus.idex_rt = 0;
        bus.exmem_mem = 0; bus.branch_taken = 0; bus.dmem_ack = 0;

        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("reset_mem_err",   32'(bus.mem_err),   32'd0);

        // Zero-wait load
        step(0, 5'd1, 5'd2, 0, 5'd0, 2'b10, 0, 1);
        idle(0);
        @(negedge clk);
        chk("zero_wait_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Load: request cycle + three unacked waits, then ack -> four stalled cycles
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 1);
        idle(0);
        @(negedge clk);
        chk("multi_wait_stall_cnt", 32'(bus.stall_cnt), 32'd4);

        // Load-use, then the rt==0 non-hazard, then branch concurrent with load-use
        step(0, 5'd5, 5'd7, 1, 5'd5, 2'b00, 0, 0);
        step(0, 5'd0, 5'd0, 1, 5'd0, 2'b00, 0, 0);
        step(0, 5'd3, 5'd9, 1, 5'd9, 2'b00, 1, 0);
        idle(0);
        @(negedge clk);
        chk("load_use_stall_cnt", 32'(bus.stall_cnt), 32'd5);

        // Back-to-back accesses with no gap, second one waits a cycle
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b01, 0, 1);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 1);

        // Timeout: store never acked, late ack in ERR ignored, rst recovers
        idle(1);
        for (int i = 0; i < TO + 1; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 2'b01, 0, 0);
        idle(0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 2'b01, 0, 1);
        @(negedge clk);
        chk("timeout_mem_err", 32'(bus.mem_err), 32'd1);
        chk("timeout_stall_cnt", 32'(bus.stall_cnt), 32'd6);
        idle(1);
        idle(0);
        @(negedge clk);
        chk("rst_clears_mem_err",   32'(bus.mem_err),   32'd0);
        chk("rst_clears_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic r;
            r = ($urandom_range(99) < 2) || (m_err && $urandom_range(99) < 20);
            step(r,
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 1'($urandom_range(1)), 5'($urandom_range(3)),
                 ($urandom_range(99) < 30) ? 2'($urandom_range(3)) : 2'b00,
                 1'($urandom_range(99) < 15), 1'($urandom_range(99) < 40));
        end

        // Saturation: hold ERR long enough to overflow 16 bits
        idle(1);
        for (int i = 0; i < TO + 1; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 2'b10, 0, 0);
        for (int i = 0; i < 70000; i++) idle(0);
        @(negedge clk);
        chk("saturated_stall_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
        idle(0);
        @(negedge clk);
        chk("saturated_no_wrap", 32'(bus.stall_cnt), 32'h0000_FFFF);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
